// File: rtl/decode_stage.sv
// Decode stage: combinational 16-bit instruction decode feeding a two-entry
// skid buffer (output register O, skid register S) with a registered fetch hold.
module decode_stage #(
  parameter int              PC_W   = 16,
  parameter logic [PC_W-1:0] NOP_PC = 16'hFFFF
) (
  input  logic            clk,
  input  logic            CPU_RESET_n,
  input  logic            in_valid,
  input  logic [15:0]     instruction,
  input  logic [PC_W-1:0] pc_in,
  input  logic            stall,
  input  logic            flush,
  output logic            fetch_hold,
  output logic            out_valid,
  output logic [2:0]      execute_op,
  output logic [3:0]      arg_0,
  output logic [3:0]      arg_1,
  output logic [2:0]      dest,
  output logic [5:0]      imm,
  output logic [PC_W-1:0] pc_out,
  output logic            illegal
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  typedef struct packed {
    logic [2:0]      op;
    logic [3:0]      a0;
    logic [3:0]      a1;
    logic [2:0]      dest;
    logic [5:0]      imm;
    logic            ill;
    logic [PC_W-1:0] pc;
  } bundle_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_LD  = 3'd2;
  localparam logic [2:0] OP_ST  = 3'd3;
  localparam logic [2:0] OP_NOP = 3'd4;

  localparam bundle_t IDLE = '{op: OP_NOP, a0: '0, a1: '0, dest: '0, imm: '0,
                               ill: 1'b0, pc: NOP_PC};

  state_t  state_q, state_d;
  bundle_t o_q, o_d, s_q, s_d, dec;
  logic    hold_d;
  logic    accept;

  always_comb begin
    dec    = IDLE;
    dec.pc = pc_in;
    unique case (instruction[15:12])
      4'd0, 4'd1: begin
        dec.op   = (instruction[15:12] == 4'd0) ? OP_ADD : OP_SUB;
        dest_fields: begin
          dec.dest = instruction[11:9];
          dec.a0   = {1'b0, instruction[8:6]};
          dec.a1   = {1'b0, instruction[5:3]};
        end
      end
      4'd2, 4'd3: begin
        dec.op   = (instruction[15:12] == 4'd2) ? OP_LD : OP_ST;
        dec.dest = instruction[11:9];
        dec.a0   = {1'b0, instruction[8:6]};
        dec.a1   = 4'h8;
        dec.imm  = instruction[5:0];
      end
      4'd4:    dec.op = OP_NOP;
      default: dec.ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge CPU_RESET_n) begin
    if (!CPU_RESET_n) begin
      state_q    <= EMPTY;
      o_q        <= IDLE;
      s_q        <= IDLE;
      fetch_hold <= 1'b0;
    end else begin
      state_q    <= state_d;
      o_q        <= o_d;
      s_q        <= s_d;
      fetch_hold <= hold_d;
    end
  end

  // In TWO the fetcher is already held, so any in_valid seen there is dropped.
  always_comb begin
    accept  = in_valid & ~flush;
    state_d = state_q;
    o_d     = o_q;
    s_d     = s_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: if (accept) begin
          o_d     = dec;
          state_d = ONE;
        end
        ONE: begin
          if (!stall) begin
            if (accept) o_d = dec;
            else        state_d = EMPTY;
          end else if (accept) begin
            s_d     = dec;
            state_d = TWO;
          end
        end
        TWO: if (!stall) begin
          o_d     = s_q;
          state_d = ONE;
        end
        default: state_d = EMPTY;
      endcase
    end
    hold_d = ~flush & ((state_d == TWO) | ((state_q == ONE) & stall));
  end

  always_comb begin
    out_valid  = (state_q != EMPTY);
    execute_op = out_valid ? o_q.op   : IDLE.op;
    arg_0      = out_valid ? o_q.a0   : IDLE.a0;
    arg_1      = out_valid ? o_q.a1   : IDLE.a1;
    dest       = out_valid ? o_q.dest : IDLE.dest;
    imm        = out_valid ? o_q.imm  : IDLE.imm;
    pc_out     = out_valid ? o_q.pc   : IDLE.pc;
    illegal    = out_valid ? o_q.ill  : IDLE.ill;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Decode stage between the fetcher and the scoreboard issue logic.
- Turns a 16-bit instruction plus its PC into a registered decoded bundle: op, two source args, dest, imm, pc.
- A two-entry skid buffer absorbs the one instruction already in flight from the synchronous instruction RAM when the scoreboard stalls.
- Drives a registered fetch hold back to the fetcher.

Parameters:
- PC_W, 16, width of PC fields.
- NOP_PC, 16'hFFFF, pc_out value while no valid instruction is presented.

Ports:
- clk  input  1  system clock, all state updates on posedge
- CPU_RESET_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  instruction/pc_in pair is valid this cycle
- instruction  input  16  raw instruction from instruction RAM q port
- pc_in  input  PC_W  PC of instruction
- stall  input  1  scoreboard cannot issue the current out_* bundle (should_fetch_stall)
- flush  input  1  discard all held instructions (branch redirect)
- fetch_hold  output  1  fetcher must not advance PC next cycle
- out_valid  output  1  decoded bundle valid
- execute_op  output  3  0 ADD, 1 SUB, 2 LOAD, 3 STORE, 4 NOP
- arg_0  output  4  {1'b0, ra}
- arg_1  output  4  {1'b0, rb}; 4'h8 when the operand is the immediate
- dest  output  3  destination register
- imm  output  6  zero-extended offset field
- pc_out  output  PC_W  PC of presented instruction
- illegal  output  1  presented instruction had an undefined opcode

Behaviour:
- Encoding:
  - [15:12] opcode, [11:9] rd, [8:6] ra, [5:3] rb, [5:0] imm.
  - Opcode 0 ADD, 1 SUB, 2 LD, 3 ST, 4 NOP.
  - Opcodes 5..15 decode to NOP with illegal=1.
- Field rules:
  - ADD/SUB: dest=rd, arg_0={0,ra}, arg_1={0,rb}, imm=0.
  - LD: dest=rd, arg_0={0,ra}, arg_1=4'h8, imm=[5:0].
  - ST: dest=rd (data source register), arg_0={0,ra}, arg_1=4'h8, imm=[5:0].
  - NOP/illegal: dest=0, arg_0=0, arg_1=0, imm=0.
- Decode is combinational on the input; results are stored decoded in the holding registers.
- Storage: output register O (drives out_*) and skid register S. States are EMPTY, ONE (O valid), TWO (O and S valid).
- Transitions (accept = in_valid & !flush):
  - EMPTY: accept -> load O, go ONE.
  - ONE, !stall: accept -> reload O; no accept -> EMPTY.
  - ONE, stall: accept -> load S, go TWO; no accept -> hold.
  - TWO, !stall: S -> O, go ONE. An in_valid arriving this cycle is dropped; fetch_hold already prevented it.
  - TWO, stall: hold. in_valid is ignored.
- fetch_hold:
  - Registered.
  - Set to 1 on the cycle after the state enters TWO, or when stall=1 while in ONE.
  - Otherwise 0.
- flush:
  - Has priority over everything.
  - Next state EMPTY; in_valid in the same cycle is discarded.
  - fetch_hold goes to 0.
- Outputs when out_valid=0: execute_op=4 (NOP), args/dest/imm=0, pc_out=NOP_PC, illegal=0.
- Reset (async assert, sync-safe release):
  - State EMPTY, out_valid=0, fetch_hold=0, execute_op=4, arg_0=0, arg_1=0, dest=0, imm=0, pc_out=NOP_PC, illegal=0.
  - Reset mid-stall drops both held instructions.
- Latency:
  - Instruction accepted at edge N appears on out_* after edge N (visible in cycle N+1).
  - Throughput is one per cycle with no stall.
- Ordering: instructions leave in arrival order. S is never overwritten while valid.

Test Plan:
- Reset, then ADD r1,r2,r3 (16'h0298) at pc 0 with stall=0 -> next cycle out_valid=1, execute_op=0, dest=1, arg_0=4'h2, arg_1=4'h3, pc_out=0.
- LD r5,[r4+6] (16'h2B06) -> execute_op=2, dest=5, arg_0=4'h4, arg_1=4'h8, imm=6.
- Stream pc 0,1,2; assert stall while pc 0 is presented, for 3 cycles -> pc 0 is held, pc 1 is captured in S, fetch_hold=1. Release stall -> pc_out sequence 0,1,2; no loss, no duplicate.
- Opcode 4'hB instruction -> execute_op=4, illegal=1, dest=0.
- State TWO plus flush=1 and in_valid=1 in the same cycle -> next cycle out_valid=0, pc_out=16'hFFFF, fetch_hold=0.
- Drive CPU_RESET_n low asynchronously mid-stall in state TWO -> outputs go to reset values immediately. After release, the first new instruction is decoded normally.
